multicycle_control_unit: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with state-gated strobes.
- Adds variable memory latency, an IN handshake with the switch interface, halt/resume and soft reset.
- Counts retired instructions. Sits between instruction register and datapath; drives PC, IR, register-file, memory and I/O enables.

---
 rtl/multicycle_control_unit_if.sv | 53 +++++
 rtl/multicycle_control_unit.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Bus between the multi-cycle control unit and the rest of the CPU.
// It carries the instruction opcode, the ALU zero flag and the switch/halt
// handshake into the controller, and all datapath strobes and status out.
//
// Modports:
//   master - the control unit (consumes opcode/alu_zero/in_valid/resume,
//            drives every control, status and handshake output)
//   slave  - the datapath / environment side (the reverse directions)
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4,
  parameter int CNT_W    = 16
);

  logic [OPCODE_W-1:0] opcode;
  logic                alu_zero;
  logic                in_valid;
  logic                resume;

  logic                ir_write;
  logic                pc_write;
  logic                cu_writeReg;
  logic                cu_regDest;
  logic                cu_memtoReg;
  logic                cu_Jump;
  logic                cu_inSignal;
  logic                cu_aluScr;
  logic                cu_writeEnable;
  logic                cu_readEnable;
  logic                cu_Branch;
  logic                cu_hlt;
  logic                cu_reset;
  logic                cu_showDisplay;
  logic [ALUOP_W-1:0]  cu_aluOp;
  logic                in_ack;
  logic                illegal;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  opcode, alu_zero, in_valid, resume,
    output ir_write, pc_write, cu_writeReg, cu_regDest, cu_memtoReg, cu_Jump,
           cu_inSignal, cu_aluScr, cu_writeEnable, cu_readEnable, cu_Branch,
           cu_hlt, cu_reset, cu_showDisplay, cu_aluOp, in_ack, illegal, retired
  );

  modport slave (
    output opcode, alu_zero, in_valid, resume,
    input  ir_write, pc_write, cu_writeReg, cu_regDest, cu_memtoReg, cu_Jump,
           cu_inSignal, cu_aluScr, cu_writeEnable, cu_readEnable, cu_Branch,
           cu_hlt, cu_reset, cu_showDisplay, cu_aluOp, in_ack, illegal, retired
  );

endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit. Each instruction walks FETCH -> DECODE ->
// EXECUTE -> (MEMORY | WAIT_IN) -> WRITEBACK, with HALT and SRESET as
// side exits from DECODE. Static datapath controls are decoded once from the
// opcode captured in FETCH and held in a register until the next FETCH, so
// no output has a combinational path from the opcode input.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   bus    - multicycle_control_unit_if.master: opcode, alu_zero, in_valid,
//            resume in; PC/IR/register/memory/I/O strobes, in_ack, sticky
//            illegal flag and retired-instruction count out
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, WAIT_IN, HALT, SRESET
  } state_t;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_dest;
    logic               alu_src;
    logic               mem_to_reg;
    logic               in_signal;
    logic               writes_reg;
    logic               is_lw;
    logic               is_sw;
    logic               is_in;
    logic               is_beq;
    logic               is_bne;
    logic               is_jump;
    logic               is_out;
  } ctrl_t;

  localparam logic [OPCODE_W-1:0] OP_HALT   = OPCODE_W'(24);
  localparam logic [OPCODE_W-1:0] OP_SRESET = OPCODE_W'(25);
  localparam logic [3:0]          MEM_LAST  = 4'(MEM_WAIT);

  state_t              state_q, next_state;
  logic [OPCODE_W-1:0] op_q;
  ctrl_t               ctrl_q;
  logic [3:0]          mem_cnt_q;
  logic [CNT_W-1:0]    retired_q;
  logic                illegal_q;
  logic                mem_last;
  logic                exec_done;
  logic                pc_write_d;

  // Opcode to static-control decode. Anything without a table entry,
  // including halt, soft reset and illegal opcodes, decodes to all zeros,
  // which is what makes an illegal opcode behave as a NOP.
  function automatic ctrl_t decode_op(input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (32'(op))
      0:  begin c.alu_op = ALUOP_W'(1);  c.writes_reg = 1'b1; end
      1:  begin c.alu_op = ALUOP_W'(2);  c.writes_reg = 1'b1; end
      2:  begin c.alu_op = ALUOP_W'(5);  c.writes_reg = 1'b1; end
      3:  begin c.alu_op = ALUOP_W'(6);  c.writes_reg = 1'b1; end
      4:  begin c.alu_op = ALUOP_W'(7);  c.writes_reg = 1'b1; end
      5:  begin c.alu_op = ALUOP_W'(11); c.writes_reg = 1'b1; end
      6:  begin c.alu_op = ALUOP_W'(12); c.writes_reg = 1'b1; end
      7:  begin c.alu_op = ALUOP_W'(13); c.writes_reg = 1'b1; end
      8:  begin c.alu_op = ALUOP_W'(14); c.writes_reg = 1'b1; end
      9:  begin c.alu_op = ALUOP_W'(2);  c.is_beq = 1'b1; end
      10: begin c.alu_op = ALUOP_W'(2);  c.is_bne = 1'b1; end
      11: begin c.alu_op = ALUOP_W'(1);  c.reg_dest = 1'b1; c.alu_src = 1'b1; c.writes_reg = 1'b1; end
      12: begin c.alu_op = ALUOP_W'(2);  c.reg_dest = 1'b1; c.alu_src = 1'b1; c.writes_reg = 1'b1; end
      13: begin c.alu_op = ALUOP_W'(3);  c.reg_dest = 1'b1; c.writes_reg = 1'b1; end
      14: begin c.alu_op = ALUOP_W'(4);  c.reg_dest = 1'b1; c.writes_reg = 1'b1; end
      15: begin
        c.alu_op = ALUOP_W'(1); c.alu_src = 1'b1; c.mem_to_reg = 1'b1;
        c.writes_reg = 1'b1; c.is_lw = 1'b1;
      end
      16: begin c.alu_op = ALUOP_W'(1);  c.alu_src = 1'b1; c.is_sw = 1'b1; end
      17: begin c.alu_op = ALUOP_W'(8);  c.reg_dest = 1'b1; c.writes_reg = 1'b1; end
      18: begin c.alu_op = ALUOP_W'(9);  c.reg_dest = 1'b1; c.alu_src = 1'b1; c.writes_reg = 1'b1; end
      19: begin c.alu_op = ALUOP_W'(10); c.reg_dest = 1'b1; c.alu_src = 1'b1; c.writes_reg = 1'b1; end
      20: begin c.alu_op = ALUOP_W'(1);  c.reg_dest = 1'b1; c.alu_src = 1'b1; c.writes_reg = 1'b1; end
      21: begin
        c.alu_op = ALUOP_W'(1); c.alu_src = 1'b1; c.in_signal = 1'b1;
        c.writes_reg = 1'b1; c.is_in = 1'b1;
      end
      22: c.is_out  = 1'b1;
      23: c.is_jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Shared conditions. Non-memory, non-writing instructions (branches, jump,
  // out, NOP) finish in EXECUTE; sw reuses WRITEBACK purely to update the
  // PC so its memory write and PC write never share a cycle.
  always_comb begin
    mem_last   = (mem_cnt_q == MEM_LAST);
    exec_done  = (state_q == EXECUTE) &&
                 !(ctrl_q.is_lw || ctrl_q.is_sw || ctrl_q.is_in || ctrl_q.writes_reg);
    pc_write_d = exec_done || (state_q == WRITEBACK) ||
                 ((state_q == HALT) && bus.resume);
  end

  // Next-state selection for the instruction sequencer.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      FETCH:     next_state = DECODE;
      DECODE: begin
        if (op_q == OP_HALT)        next_state = HALT;
        else if (op_q == OP_SRESET) next_state = SRESET;
        else                        next_state = EXECUTE;
      end
      EXECUTE: begin
        if (ctrl_q.is_lw || ctrl_q.is_sw) next_state = MEMORY;
        else if (ctrl_q.is_in)            next_state = WAIT_IN;
        else if (ctrl_q.writes_reg)       next_state = WRITEBACK;
        else                              next_state = FETCH;
      end
      MEMORY:    if (mem_last) next_state = WRITEBACK;
      WAIT_IN:   if (bus.in_valid) next_state = WRITEBACK;
      WRITEBACK: next_state = FETCH;
      HALT:      if (bus.resume) next_state = FETCH;
      SRESET:    next_state = FETCH;
      default:   next_state = FETCH;
    endcase
  end

  // Sequencer state, captured opcode and its decoded controls, memory wait
  // counter, sticky illegal flag and retired count. Controls are loaded when
  // leaving FETCH and cleared on every return to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      op_q      <= '0;
      ctrl_q    <= '0;
      mem_cnt_q <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= next_state;
      if (state_q == FETCH) begin
        op_q   <= bus.opcode;
        ctrl_q <= decode_op(bus.opcode);
      end else if (next_state == FETCH) begin
        ctrl_q <= '0;
      end
      mem_cnt_q <= (state_q == MEMORY) ? mem_cnt_q + 4'd1 : 4'd0;
      if ((state_q == DECODE) && (op_q > OP_SRESET)) illegal_q <= 1'b1;
      if (state_q == SRESET)  retired_q <= '0;
      else if (pc_write_d)    retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Output drive. Everything except ir_write is forced low while reset is
  // high, so a store interrupted in its last MEMORY cycle never writes.
  always_comb begin
    bus.ir_write       = (state_q == FETCH);
    bus.pc_write       = 1'b0;
    bus.cu_writeReg    = 1'b0;
    bus.cu_regDest     = 1'b0;
    bus.cu_memtoReg    = 1'b0;
    bus.cu_Jump        = 1'b0;
    bus.cu_inSignal    = 1'b0;
    bus.cu_aluScr      = 1'b0;
    bus.cu_writeEnable = 1'b0;
    bus.cu_readEnable  = 1'b0;
    bus.cu_Branch      = 1'b0;
    bus.cu_hlt         = 1'b0;
    bus.cu_reset       = 1'b0;
    bus.cu_showDisplay = 1'b0;
    bus.cu_aluOp       = '0;
    bus.in_ack         = 1'b0;
    if (!reset) begin
      bus.pc_write       = pc_write_d;
      bus.cu_writeReg    = (state_q == WRITEBACK) && ctrl_q.writes_reg;
      bus.cu_regDest     = ctrl_q.reg_dest;
      bus.cu_memtoReg    = ctrl_q.mem_to_reg;
      bus.cu_inSignal    = ctrl_q.in_signal;
      bus.cu_aluScr      = ctrl_q.alu_src;
      bus.cu_aluOp       = ctrl_q.alu_op;
      bus.cu_Jump        = (state_q == EXECUTE) && ctrl_q.is_jump;
      bus.cu_showDisplay = (state_q == EXECUTE) && ctrl_q.is_out;
      bus.cu_Branch      = (state_q == EXECUTE) &&
                           ((ctrl_q.is_beq && bus.alu_zero) || (ctrl_q.is_bne && !bus.alu_zero));
      bus.cu_readEnable  = (state_q == MEMORY) && ctrl_q.is_lw;
      bus.cu_writeEnable = (state_q == MEMORY) && ctrl_q.is_sw && mem_last;
      bus.cu_hlt         = (state_q == HALT);
      bus.cu_reset       = (state_q == SRESET);
      bus.in_ack         = (state_q == WAIT_IN) && bus.in_valid;
    end
  end

  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit. Two instances run the same
// instruction stream: the main one with a 16-bit retired counter and a
// second with a 2-bit counter to exercise wrap-around. Both use MEM_WAIT=2.
// Each cycle is described by a record of inputs and hand-derived expected
// outputs; the straight-line program lives in a table, the multi-cycle
// corners (input wait, halt, soft reset, reset mid-store) are written out.
module tb_multicycle_control_unit;

  localparam logic [15:0] F_IR = 16'h8000;
  localparam logic [15:0] F_PC = 16'h4000;
  localparam logic [15:0] F_WR = 16'h2000;
  localparam logic [15:0] F_RD = 16'h1000;
  localparam logic [15:0] F_MR = 16'h0800;
  localparam logic [15:0] F_JP = 16'h0400;
  localparam logic [15:0] F_IS = 16'h0200;
  localparam logic [15:0] F_AS = 16'h0100;
  localparam logic [15:0] F_WE = 16'h0080;
  localparam logic [15:0] F_RE = 16'h0040;
  localparam logic [15:0] F_BR = 16'h0020;
  localparam logic [15:0] F_HL = 16'h0010;
  localparam logic [15:0] F_SR = 16'h0008;
  localparam logic [15:0] F_DS = 16'h0004;
  localparam logic [15:0] F_AK = 16'h0002;
  localparam logic [15:0] F_IL = 16'h0001;

  typedef struct {
    string       tag;
    logic        rst;
    logic [5:0]  op;
    logic        az;
    logic        iv;
    logic        rs;
    logic [15:0] flags;
    logic [3:0]  aop;
    int          ret;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(4), .CNT_W(16)) bus ();
  multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(4), .CNT_W(2))  bus2 ();

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(4), .MEM_WAIT(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(4), .MEM_WAIT(2), .CNT_W(2)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // The wrap-around instance mirrors every input of the main one.
  assign bus2.opcode   = bus.opcode;
  assign bus2.alu_zero = bus.alu_zero;
  assign bus2.in_valid = bus.in_valid;
  assign bus2.resume   = bus.resume;

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input string tag, input logic rst, input logic [5:0] op,
                              input logic az, input logic iv, input logic rs,
                              input logic [15:0] fl, input logic [3:0] aop, input int ret);
    vec_t v;
    v.tag = tag; v.rst = rst; v.op = op; v.az = az; v.iv = iv; v.rs = rs;
    v.flags = fl; v.aop = aop; v.ret = ret;
    return v;
  endfunction

  // Drive one cycle's inputs shortly after the rising edge and let them settle.
  task automatic applyStimulus(input vec_t v);
    reset        = v.rst;
    bus.opcode   = v.op;
    bus.alu_zero = v.az;
    bus.in_valid = v.iv;
    bus.resume   = v.rs;
    #2;
  endtask

  // Compare strobes, ALU op and both retired counters against the record.
  task automatic checkOutput(input vec_t v);
    logic [15:0] act;
    logic [1:0]  exp2;
    act = {bus.ir_write, bus.pc_write, bus.cu_writeReg, bus.cu_regDest,
           bus.cu_memtoReg, bus.cu_Jump, bus.cu_inSignal, bus.cu_aluScr,
           bus.cu_writeEnable, bus.cu_readEnable, bus.cu_Branch, bus.cu_hlt,
           bus.cu_reset, bus.cu_showDisplay, bus.in_ack, bus.illegal};
    checks++;
    if (act !== v.flags) begin
      errors++;
      $display("[TB] FAIL %s flags: got %04h expected %04h", v.tag, act, v.flags);
    end
    checks++;
    if (bus.cu_aluOp !== v.aop) begin
      errors++;
      $display("[TB] FAIL %s aluOp: got %0d expected %0d", v.tag, bus.cu_aluOp, v.aop);
    end
    checks++;
    if (bus.retired !== 16'(v.ret)) begin
      errors++;
      $display("[TB] FAIL %s retired: got %0d expected %0d", v.tag, bus.retired, v.ret);
    end
    exp2 = 2'(v.ret % 4);
    checks++;
    if (bus2.retired !== exp2) begin
      errors++;
      $display("[TB] FAIL %s retired_w2: got %0d expected %0d", v.tag, bus2.retired, exp2);
    end
  endtask

  task automatic run(input vec_t v);
    applyStimulus(v);
    checkOutput(v);
    @(posedge clk);
    #1;
  endtask

  // Main test sequence.
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.opcode = '0; bus.alu_zero = 1'b0; bus.in_valid = 1'b0; bus.resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Straight-line program: one record per clock cycle.
    vecs.push_back(mk("add F", 0, 0, 0, 0, 0, F_IR, 0, 0));
    vecs.push_back(mk("add D", 0, 0, 0, 0, 0, 16'h0, 1, 0));
    vecs.push_back(mk("add E", 0, 0, 0, 0, 0, 16'h0, 1, 0));
    vecs.push_back(mk("add W", 0, 0, 0, 0, 0, F_PC | F_WR, 1, 0));
    vecs.push_back(mk("lw F", 0, 15, 0, 0, 0, F_IR, 0, 1));
    vecs.push_back(mk("lw D", 0, 15, 0, 0, 0, F_AS | F_MR, 1, 1));
    vecs.push_back(mk("lw E", 0, 15, 0, 0, 0, F_AS | F_MR, 1, 1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk("lw M", 0, 15, 0, 0, 0, F_AS | F_MR | F_RE, 1, 1));
    vecs.push_back(mk("lw W", 0, 15, 0, 0, 0, F_AS | F_MR | F_PC | F_WR, 1, 1));
    vecs.push_back(mk("sw F", 0, 16, 0, 0, 0, F_IR, 0, 2));
    vecs.push_back(mk("sw D", 0, 16, 0, 0, 0, F_AS, 1, 2));
    vecs.push_back(mk("sw E", 0, 16, 0, 0, 0, F_AS, 1, 2));
    vecs.push_back(mk("sw M0", 0, 16, 0, 0, 0, F_AS, 1, 2));
    vecs.push_back(mk("sw M1", 0, 16, 0, 0, 0, F_AS, 1, 2));
    vecs.push_back(mk("sw M2", 0, 16, 0, 0, 0, F_AS | F_WE, 1, 2));
    vecs.push_back(mk("sw W", 0, 16, 0, 0, 0, F_AS | F_PC, 1, 2));
    vecs.push_back(mk("beq1 F", 0, 9, 1, 0, 0, F_IR, 0, 3));
    vecs.push_back(mk("beq1 D", 0, 9, 1, 0, 0, 16'h0, 2, 3));
    vecs.push_back(mk("beq1 E", 0, 9, 1, 0, 0, F_BR | F_PC, 2, 3));
    vecs.push_back(mk("beq0 F", 0, 9, 0, 0, 0, F_IR, 0, 4));
    vecs.push_back(mk("beq0 D", 0, 9, 0, 0, 0, 16'h0, 2, 4));
    vecs.push_back(mk("beq0 E", 0, 9, 0, 0, 0, F_PC, 2, 4));
    vecs.push_back(mk("bne0 F", 0, 10, 0, 0, 0, F_IR, 0, 5));
    vecs.push_back(mk("bne0 D", 0, 10, 0, 0, 0, 16'h0, 2, 5));
    vecs.push_back(mk("bne0 E", 0, 10, 0, 0, 0, F_BR | F_PC, 2, 5));
    vecs.push_back(mk("bne1 F", 0, 10, 1, 0, 0, F_IR, 0, 6));
    vecs.push_back(mk("bne1 D", 0, 10, 1, 0, 0, 16'h0, 2, 6));
    vecs.push_back(mk("bne1 E", 0, 10, 1, 0, 0, F_PC, 2, 6));
    vecs.push_back(mk("jmp F", 0, 23, 0, 0, 0, F_IR, 0, 7));
    vecs.push_back(mk("jmp D", 0, 23, 0, 0, 0, 16'h0, 0, 7));
    vecs.push_back(mk("jmp E", 0, 23, 0, 0, 0, F_JP | F_PC, 0, 7));
    vecs.push_back(mk("out F", 0, 22, 0, 0, 0, F_IR, 0, 8));
    vecs.push_back(mk("out D", 0, 22, 0, 0, 0, 16'h0, 0, 8));
    vecs.push_back(mk("out E", 0, 22, 0, 0, 0, F_DS | F_PC, 0, 8));
    vecs.push_back(mk("addi F", 0, 11, 0, 0, 0, F_IR, 0, 9));
    vecs.push_back(mk("addi D", 0, 11, 0, 0, 0, F_RD | F_AS, 1, 9));
    vecs.push_back(mk("addi E", 0, 11, 0, 0, 0, F_RD | F_AS, 1, 9));
    vecs.push_back(mk("addi W", 0, 11, 0, 0, 0, F_RD | F_AS | F_PC | F_WR, 1, 9));
    vecs.push_back(mk("inc F", 0, 13, 0, 0, 0, F_IR, 0, 10));
    vecs.push_back(mk("inc D", 0, 13, 0, 0, 0, F_RD, 3, 10));
    vecs.push_back(mk("inc E", 0, 13, 0, 0, 0, F_RD, 3, 10));
    vecs.push_back(mk("inc W", 0, 13, 0, 0, 0, F_RD | F_PC | F_WR, 3, 10));
    vecs.push_back(mk("not F", 0, 17, 0, 0, 0, F_IR, 0, 11));
    vecs.push_back(mk("not D", 0, 17, 0, 0, 0, F_RD, 8, 11));
    vecs.push_back(mk("not E", 0, 17, 0, 0, 0, F_RD, 8, 11));
    vecs.push_back(mk("not W", 0, 17, 0, 0, 0, F_RD | F_PC | F_WR, 8, 11));
    vecs.push_back(mk("sll F", 0, 18, 0, 0, 0, F_IR, 0, 12));
    vecs.push_back(mk("sll D", 0, 18, 0, 0, 0, F_RD | F_AS, 9, 12));
    vecs.push_back(mk("sll E", 0, 18, 0, 0, 0, F_RD | F_AS, 9, 12));
    vecs.push_back(mk("sll W", 0, 18, 0, 0, 0, F_RD | F_AS | F_PC | F_WR, 9, 12));
    vecs.push_back(mk("ill F", 0, 40, 0, 0, 0, F_IR, 0, 13));
    vecs.push_back(mk("ill D", 0, 40, 0, 0, 0, 16'h0, 0, 13));
    vecs.push_back(mk("ill E", 0, 40, 0, 0, 0, F_IL | F_PC, 0, 13));

    $display("[TB] reset state");
    run(mk("reset", 1, 0, 0, 0, 0, F_IR, 0, 0));

    $display("[TB] table: %0d cycles", vecs.size());
    foreach (vecs[i]) run(vecs[i]);

    // in with in_valid raised four cycles into WAIT_IN.
    run(mk("inL F", 0, 21, 0, 0, 0, F_IR | F_IL, 0, 14));
    run(mk("inL D", 0, 21, 0, 0, 0, F_IS | F_AS | F_IL, 1, 14));
    run(mk("inL E", 0, 21, 0, 0, 0, F_IS | F_AS | F_IL, 1, 14));
    for (int k = 0; k < 4; k++)
      run(mk("inL wait", 0, 21, 0, 0, 0, F_IS | F_AS | F_IL, 1, 14));
    run(mk("inL ack", 0, 21, 0, 1, 0, F_IS | F_AS | F_IL | F_AK, 1, 14));
    run(mk("inL W", 0, 21, 0, 0, 0, F_IS | F_AS | F_IL | F_WR | F_PC, 1, 14));

    // in with in_valid already high before WAIT_IN.
    run(mk("inP F", 0, 21, 0, 1, 0, F_IR | F_IL, 0, 15));
    run(mk("inP D", 0, 21, 0, 1, 0, F_IS | F_AS | F_IL, 1, 15));
    run(mk("inP E", 0, 21, 0, 1, 0, F_IS | F_AS | F_IL, 1, 15));
    run(mk("inP ack", 0, 21, 0, 1, 0, F_IS | F_AS | F_IL | F_AK, 1, 15));
    run(mk("inP W", 0, 21, 0, 0, 0, F_IS | F_AS | F_IL | F_WR | F_PC, 1, 15));

    // Halt for ten cycles, then resume.
    run(mk("hlt F", 0, 24, 0, 0, 0, F_IR | F_IL, 0, 16));
    run(mk("hlt D", 0, 24, 0, 0, 0, F_IL, 0, 16));
    for (int k = 0; k < 10; k++)
      run(mk("hlt hold", 0, 24, 0, 0, 0, F_HL | F_IL, 0, 16));
    run(mk("hlt resume", 0, 24, 0, 0, 1, F_HL | F_PC | F_IL, 0, 16));

    // Soft reset clears retired but leaves illegal set.
    run(mk("srst F", 0, 25, 0, 0, 0, F_IR | F_IL, 0, 17));
    run(mk("srst D", 0, 25, 0, 0, 0, F_IL, 0, 17));
    run(mk("srst S", 0, 25, 0, 0, 0, F_SR | F_IL, 0, 17));
    run(mk("add2 F", 0, 0, 0, 0, 0, F_IR | F_IL, 0, 0));
    run(mk("add2 D", 0, 0, 0, 0, 0, F_IL, 1, 0));
    run(mk("add2 E", 0, 0, 0, 0, 0, F_IL, 1, 0));
    run(mk("add2 W", 0, 0, 0, 0, 0, F_IL | F_PC | F_WR, 1, 0));

    // Hard reset in the final MEMORY cycle of a store.
    run(mk("swR F", 0, 16, 0, 0, 0, F_IR | F_IL, 0, 1));
    run(mk("swR D", 0, 16, 0, 0, 0, F_AS | F_IL, 1, 1));
    run(mk("swR E", 0, 16, 0, 0, 0, F_AS | F_IL, 1, 1));
    run(mk("swR M0", 0, 16, 0, 0, 0, F_AS | F_IL, 1, 1));
    run(mk("swR M1", 0, 16, 0, 0, 0, F_AS | F_IL, 1, 1));
    run(mk("swR M2rst", 1, 16, 0, 0, 0, F_IL, 0, 1));
    run(mk("swR after", 0, 16, 0, 0, 0, F_IR, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
